mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
Sequencer that sits directly upstream of the 4:1 mux (mux4_1).
- Drives the mux select lines s1/s2 through the enabled channels, holding each for a programmable dwell time.
- Samples the mux output once per channel and assembles a 4-bit frame.
- Provides a start/busy/done handshake to the surrounding control logic.

Parameters:
- DWELL, 4: cycles each channel is selected before sampling; legal range 1..255.
- CNT_W, 8: width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: scan request; sampled only in IDLE.
- chan_en, input, 4: channel enable mask (bit0=a, bit1=b, bit2=c, bit3=d); latched at start.
- mux_out, input, 1: the mux output (out of mux4_1).
- s1, output, 1: select LSB to the mux.
- s2, output, 1: select MSB to the mux; {s2,s1}: 00=a, 01=b, 10=c, 11=d.
- busy, output, 1: high while a scan is in progress.
- done, output, 1: one-cycle pulse at end of scan.
- sample_valid, output, 1: one-cycle pulse per sampled channel.
- sample_chan, output, 2: channel index of the current sample.
- sample_bit, output, 1: sampled mux_out value.
- frame, output, 4: frame[i] = last sampled value of channel i; bits of unvisited channels cleared.

Behaviour:
- Reset (asynchronous, any cycle including mid-scan): all outputs 0, state=IDLE, counter=0, latched mask=0.
- All outputs are registered. The select lines are never driven from combinational logic.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - s1/s2 hold 00; busy=0.
  - start=1 and chan_en!=0: latch mask, clear frame, load lowest enabled channel into select, counter=0, go to SETTLE.
  - start=1 and chan_en==0: clear frame, go to DONE; no select change, no samples.
- SETTLE:
  - Select holds the current channel; counter increments each cycle.
  - At the edge where counter==DWELL-1, capture mux_out. That edge registers sample_valid=1, sample_chan=current channel, sample_bit=mux_out, and frame[chan]=mux_out.
  - Same edge: if a higher enabled channel exists, select it with counter=0 and stay in SETTLE; otherwise go to DONE.
- DONE: lasts one cycle, then done=1 is registered for one cycle and state returns to IDLE.
- busy is 1 in SETTLE and DONE, 0 in IDLE.
- Timing: the start edge is edge 0. Samples occur at edges k*DWELL, k=1..N, where N = number of enabled channels. done is high during the cycle after edge N*DWELL+1.
- A new start is accepted in the same cycle done is high, since state is already IDLE.
- start while busy is ignored. chan_en changes during a scan are ignored.
- DWELL=1: each channel is sampled at the end of its first selected cycle.
- The channel order is always ascending index. Disabled channels are skipped with no dwell cycles spent on them.

Optional Feature:
- Macro: MUX_SCAN_CONT_EN.
- Defined:
  - Adds input port cont (1 bit).
  - In DONE with cont=1 and latched mask !=0, the block pulses done and restarts at the lowest enabled channel of the latched mask (counter=0, frame cleared) instead of returning to IDLE; busy stays 1.
  - cont=0 behaves as the base design.
- Undefined: no cont port; every scan is single-shot.

Decomposition:
- Package mux_scan_pkg holds:
  - state enum {IDLE, SETTLE, DONE};
  - NUM_CH=4;
  - SEL_W=2;
  - select encoding constants CH_A..CH_D.
- One combinational sub-module, mux_scan_next_chan. It takes the mask and the current channel, and returns the next higher enabled channel plus a "found" flag. The same block with current=-1 supplies the first channel, so there is a single source of truth for skip logic.

Test Plan:
- DWELL=4, chan_en=1111, bench mux with a=1,b=0,c=1,d=0, start pulse -> select 00,01,10,11 for 4 cycles each; sample_valid at edges 4,8,12,16 with bits 1,0,1,0; frame=0101; done after edge 17.
- chan_en=1010, same inputs -> only selects 01 and 11; samples 0,0 on channels 1,3; frame=0000; done after edge 9; selects 00/10 never driven during the scan.
- chan_en=0000, start -> done after edge 1; no sample_valid; frame=0000; s1/s2 stay 00.
- start re-pulsed at edge 6 of a 1111 scan -> ignored; sequence and done timing identical to scenario 1; start asserted in the done cycle -> new scan begins.
- rst_n low asynchronously while channel 2 is selected -> all outputs 0 immediately without a clock edge; after release, start with 0100 -> only channel 2 sampled, done after edge 5.
- MUX_SCAN_CONT_EN defined, cont=1, chan_en=0011, DWELL=2 -> done pulses every 5 cycles with busy held 1; drop cont -> the current scan finishes, then IDLE.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the mux4_1 scan sequencer.
//   state_t    : sequencer FSM states (IDLE, SETTLE, DONE)
//   NUM_CH     : number of mux channels
//   SEL_W      : width of the {s2,s1} select code
//   CH_A..CH_D : select encodings for channels a..d
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] CH_A = 2'd0;
  localparam logic [SEL_W-1:0] CH_B = 2'd1;
  localparam logic [SEL_W-1:0] CH_C = 2'd2;
  localparam logic [SEL_W-1:0] CH_D = 2'd3;

endpackage

// File: rtl/mux_scan_next_chan.sv
// mux_scan_next_chan: combinational search for the next enabled channel.
// Returns the lowest enabled channel whose index is strictly greater than
// cur. cur is SEL_W+1 bits so that all-ones (-1) asks for the first
// enabled channel; this block is the only place channel skipping is decided.
//   mask  : in,  channel enable mask (bit i = channel i)
//   cur   : in,  current channel, or all-ones for "before channel 0"
//   nxt   : out, next enabled channel (CH_A when none found)
//   found : out, high when a higher enabled channel exists
module mux_scan_next_chan
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W:0]    cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              found
);

  logic [SEL_W:0] lo;

  always_comb begin
    nxt   = CH_A;
    found = 1'b0;
    // -1 wraps to 0, channel 3 becomes 4 (beyond the last channel)
    lo    = cur + {{SEL_W{1'b0}}, 1'b1};
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && mask[i] && (i >= 32'(lo))) begin
        found = 1'b1;
        nxt   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scan sequencer driving the select lines of mux4_1.
// Steps through the enabled channels in ascending order, holds each for
// DWELL cycles, samples mux_out at the end of the dwell and builds a
// 4-bit frame. All outputs are registered.
// Optional feature macro: MUX_SCAN_CONT_EN (adds 'cont' for back-to-back
// scans of the latched mask).
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : scan request, honoured only in IDLE
//   chan_en      : channel enable mask, latched at start
//   mux_out      : output of the mux being scanned
//   cont         : (MUX_SCAN_CONT_EN only) restart scan instead of idling
//   s1, s2       : select LSB / MSB to the mux
//   busy, done   : scan in progress / one-cycle end-of-scan pulse
//   sample_valid : one-cycle pulse per sampled channel
//   sample_chan  : channel index of the sample
//   sample_bit   : sampled mux_out value
//   frame        : last sampled value per channel, unvisited bits cleared
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic              mux_out,
`ifdef MUX_SCAN_CONT_EN
  input  logic              cont,
`endif
  output logic              s1,
  output logic              s2,
  output logic              busy,
  output logic              done,
  output logic              sample_valid,
  output logic [SEL_W-1:0]  sample_chan,
  output logic              sample_bit,
  output logic [NUM_CH-1:0] frame
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  state_t              state_q, state_n;
  logic [SEL_W-1:0]    sel_q, sel_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [NUM_CH-1:0]   mask_q, mask_n;
  logic [NUM_CH-1:0]   frame_q, frame_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                sv_q, sv_n;
  logic [SEL_W-1:0]    sc_q, sc_n;
  logic                sb_q, sb_n;

  logic [NUM_CH-1:0]   nc_mask;
  logic [SEL_W:0]      nc_cur;
  logic [SEL_W-1:0]    nc_ch;
  logic                nc_found;
  logic                restart;

`ifdef MUX_SCAN_CONT_EN
  assign restart = cont && (mask_q != '0);
`else
  assign restart = 1'b0;
`endif

  // One search block serves both "first channel" (cur = -1) and
  // "next channel" (cur = current select) lookups.
  assign nc_mask = (state_q == IDLE) ? chan_en : mask_q;
  assign nc_cur  = (state_q == SETTLE) ? {1'b0, sel_q} : '1;

  mux_scan_next_chan u_next_chan (
    .mask  (nc_mask),
    .cur   (nc_cur),
    .nxt   (nc_ch),
    .found (nc_found)
  );

  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    cnt_n   = cnt_q;
    mask_n  = mask_q;
    frame_n = frame_q;
    done_n  = 1'b0;
    sv_n    = 1'b0;
    sc_n    = sc_q;
    sb_n    = sb_q;

    unique case (state_q)
      IDLE: begin
        sel_n = CH_A;
        if (start) begin
          frame_n = '0;
          mask_n  = chan_en;
          if (chan_en != '0) begin
            sel_n   = nc_ch;
            cnt_n   = '0;
            state_n = SETTLE;
          end else begin
            state_n = DONE;
          end
        end
      end

      SETTLE: begin
        cnt_n = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sv_n           = 1'b1;
          sc_n           = sel_q;
          sb_n           = mux_out;
          frame_n[sel_q] = mux_out;
          cnt_n          = '0;
          if (nc_found) begin
            sel_n = nc_ch;
          end else begin
            state_n = DONE;
          end
        end
      end

      DONE: begin
        done_n = 1'b1;
        if (restart) begin
          sel_n   = nc_ch;
          cnt_n   = '0;
          frame_n = '0;
          state_n = SETTLE;
        end else begin
          sel_n   = CH_A;
          state_n = IDLE;
        end
      end

      default: begin
        sel_n   = CH_A;
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= CH_A;
      cnt_q   <= '0;
      mask_q  <= '0;
      frame_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sv_q    <= 1'b0;
      sc_q    <= '0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      cnt_q   <= cnt_n;
      mask_q  <= mask_n;
      frame_q <= frame_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      sv_q    <= sv_n;
      sc_q    <= sc_n;
      sb_q    <= sb_n;
    end
  end

  assign s1           = sel_q[0];
  assign s2           = sel_q[1];
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_valid = sv_q;
  assign sample_chan  = sc_q;
  assign sample_bit   = sb_q;
  assign frame        = frame_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed bench for mux_scan_ctrl with a behavioural
// 4:1 mux (a=1, b=0, c=1, d=0) closing the loop from s1/s2 to mux_out.
module tb_mux_scan_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] chan_en = 4'b0000;
  logic       mux_out;
  logic       s1, s2, busy, done, sample_valid, sample_bit;
  logic [1:0] sample_chan;
  logic [3:0] frame;
  logic [3:0] data = 4'b0101;

  int tests = 0;
  int fails = 0;

  assign mux_out = data[{s2, s1}];

  mux_scan_ctrl #(.DWELL(D), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .chan_en      (chan_en),
    .mux_out      (mux_out),
`ifdef MUX_SCAN_CONT_EN
    .cont         (1'b0),
`endif
    .s1           (s1),
    .s2           (s2),
    .busy         (busy),
    .done         (done),
    .sample_valid (sample_valid),
    .sample_chan  (sample_chan),
    .sample_bit   (sample_bit),
    .frame        (frame)
  );

`ifdef MUX_SCAN_CONT_EN
  logic       c_start = 1'b0, c_cont = 1'b0;
  logic [3:0] c_en = 4'b0000;
  logic       c_mux_out, c_s1, c_s2, c_busy, c_done, c_sv, c_sb;
  logic [1:0] c_sc;
  logic [3:0] c_frame;

  assign c_mux_out = data[{c_s2, c_s1}];

  mux_scan_ctrl #(.DWELL(2), .CNT_W(8)) dut_cont (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (c_start),
    .chan_en      (c_en),
    .mux_out      (c_mux_out),
    .cont         (c_cont),
    .s1           (c_s1),
    .s2           (c_s2),
    .busy         (c_busy),
    .done         (c_done),
    .sample_valid (c_sv),
    .sample_chan  (c_sc),
    .sample_bit   (c_sb),
    .frame        (c_frame)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one scan from a point 1ns after a clock edge. ch0..ch3 list the
  // enabled channels in visiting order; n is how many. repulse > 0 raises
  // start again just before that edge. Returns in the done cycle.
  task automatic scan(input logic [3:0] en, input int n,
                      input logic [1:0] ch0, input logic [1:0] ch1,
                      input logic [1:0] ch2, input logic [1:0] ch3,
                      input logic [3:0] exp_frame, input int repulse);
    logic [1:0] ch[4];
    logic [1:0] exp_sel, k;
    logic       exp_busy, exp_done, exp_sv;
    ch = '{ch0, ch1, ch2, ch3};
    start   = 1'b1;
    chan_en = en;
    @(posedge clk);
    #1;
    start   = 1'b0;
    chan_en = ~en;
    for (int e = 0; e <= n * D + 1; e++) begin
      if (e > 0) begin
        if (e == repulse) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      if (e == n * D + 1 || n == 0) exp_sel = 2'd0;
      else if (e == n * D)          exp_sel = ch[n - 1];
      else                          exp_sel = ch[e / D];
      exp_busy = (e <= n * D);
      exp_done = (e == n * D + 1);
      exp_sv   = (e > 0) && (e <= n * D) && (e % D == 0);
      check("ctl", 8'({s2, s1, busy, done, sample_valid}),
                   8'({exp_sel, exp_busy, exp_done, exp_sv}));
      if (exp_sv) begin
        k = ch[e / D - 1];
        check("sample", 8'({sample_chan, sample_bit}), 8'({k, data[k]}));
      end
    end
    check("frame", 8'(frame), 8'(exp_frame));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_out", {s2, s1, busy, done, sample_valid, sample_chan, sample_bit}, 8'h00);
    check("reset_frame", 8'(frame), 8'h00);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full scan with an ignored start at edge 6, then a start in the done cycle.
    scan(4'b1111, 4, 2'd0, 2'd1, 2'd2, 2'd3, 4'b0101, 6);
    scan(4'b1010, 2, 2'd1, 2'd3, 2'd0, 2'd0, 4'b0000, -1);
    @(posedge clk);
    #1;
    check("idle_after", 8'({s2, s1, busy, done, sample_valid}), 8'h00);

    scan(4'b1111, 4, 2'd0, 2'd1, 2'd2, 2'd3, 4'b0101, -1);
    scan(4'b0000, 0, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000, -1);

    // Asynchronous reset while channel 2 is selected.
    start   = 1'b1;
    chan_en = 4'b1111;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_reset_sel", 8'({s2, s1, busy}), 8'b101);
    check("pre_reset_frame", 8'(frame), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", {s2, s1, busy, done, sample_valid, sample_chan, sample_bit}, 8'h00);
    check("async_reset_frame", 8'(frame), 8'h00);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    scan(4'b0100, 1, 2'd2, 2'd0, 2'd0, 2'd0, 4'b0100, -1);

`ifdef MUX_SCAN_CONT_EN
    // Continuous mode, DWELL=2, channels a and b: done every 5 cycles.
    c_cont  = 1'b1;
    c_start = 1'b1;
    c_en    = 4'b0011;
    @(posedge clk);
    #1;
    c_start = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      if (e == 12) c_cont = 1'b0;
      @(posedge clk);
      #1;
      check("cont", 8'({c_busy, c_done}),
            8'({(e < 15) ? 1'b1 : 1'b0, (e % 5 == 0 && e <= 15) ? 1'b1 : 1'b0}));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
